// File: rtl/sc_disp_pkg.sv
// Shared definitions for the output-port display back-end: FSM states,
// active-low gfedcba segment patterns and the BCD digit-correction helper.
package sc_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } disp_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry k is the pattern for decimal digit k (entry 0 sits in the LSBs).
    localparam logic [9:0][6:0] SEG_PATTERN = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Double-dabble pre-shift correction: a nibble of 5..9 would carry past 9 after doubling.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/sc_seg7_decode.sv
// One seven-segment digit: BCD digit plus blank request to active-low gfedcba.
// Non-decimal codes are shown blank rather than as garbage.
module sc_seg7_decode
    import sc_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i && (digit_i <= 4'd9)) begin
            seg_o = SEG_PATTERN[digit_i];
        end
    end

endmodule

// File: rtl/sc_out_display.sv
// Drives seven-segment digits with the unsigned decimal value of a 32-bit word,
// re-running a one-bit-per-clock double-dabble conversion whenever the word changes.
module sc_out_display
    import sc_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             value_in,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    overflow,
    output logic                    busy,
    output logic                    update
);

    disp_state_e             state_q, state_d;
    logic [31:0]             last_q, last_d;
    logic                    pend_q, pend_d;
    logic [31:0]             sh_q, sh_d;
    logic [39:0]             bcd_q, bcd_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    ovf_q, ovf_d;
    logic                    busy_q, busy_d;
    logic                    update_q, update_d;

    logic [39:0]             bcd_adj;
    logic                    ovf_now;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [7*NUM_DIGITS-1:0] seg_dec;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = bcd_adjust(bcd_q[4*gi +: 4]);
        end
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            sc_seg7_decode u_dec (
                .digit_i (bcd_q[4*gi +: 4]),
                .blank_i (blank_vec[gi]),
                .seg_o   (seg_dec[7*gi +: 7])
            );
        end
    endgenerate

    // Any nonzero BCD digit above the shown ones means the value does not fit.
    assign ovf_now = |(bcd_q >> (4*NUM_DIGITS));

    // Walk from the top digit down; a digit is blank while every digit above it was zero.
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (bcd_q[4*k +: 4] == 4'd0);
            if (k > 0) begin
                blank_vec[k] = BLANK_LZ && zero_run && !ovf_now;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        pend_d   = pend_q;
        sh_d     = sh_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        hex_d    = hex_q;
        ovf_d    = ovf_q;
        update_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q || (value_in != last_q)) begin
                    sh_d    = value_in;
                    last_d  = value_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
                cnt_d         = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                hex_d    = seg_dec;
                ovf_d    = ovf_now;
                update_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_q   <= '0;
            pend_q   <= 1'b1;
            sh_q     <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            hex_q    <= {NUM_DIGITS{SEG_BLANK}};
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            sh_q     <= sh_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            hex_q    <= hex_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            update_q <= update_d;
        end
    end

    assign hex_out  = hex_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign update   = update_q;

endmodule

// File: tb/tb_sc_out_display.sv
// Bench for sc_out_display: a 6-digit and a 10-digit instance share the same
// inputs and are compared against a decimal-arithmetic model of the display.
module tb_sc_out_display;

    logic        clock;
    logic        reset;
    logic [31:0] value_in;

    logic [41:0] hex6;
    logic [69:0] hex10;
    logic        ovf6, ovf10, busy6, busy10, upd6, upd10;

    int tests = 0;
    int fails = 0;

    logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    sc_out_display u_dut6 (
        .clock    (clock),
        .reset    (reset),
        .value_in (value_in),
        .hex_out  (hex6),
        .overflow (ovf6),
        .busy     (busy6),
        .update   (upd6)
    );

    sc_out_display #(.NUM_DIGITS(10)) u_dut10 (
        .clock    (clock),
        .reset    (reset),
        .value_in (value_in),
        .hex_out  (hex10),
        .overflow (ovf10),
        .busy     (busy10),
        .update   (upd10)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic exp_ovf(input longint unsigned v, input int n);
        return v >= pow10(n);
    endfunction

    // Expected segment bus from plain decimal arithmetic on the value.
    function automatic logic [69:0] exp_hex(input longint unsigned v, input int n);
        logic [69:0]     r;
        longint unsigned p;
        int              digit;
        r = '0;
        p = 1;
        for (int k = 0; k < n; k++) begin
            digit = int'((v / p) % 10);
            if (k > 0 && !exp_ovf(v, n) && v < p) r[7*k +: 7] = 7'h7F;
            else                                  r[7*k +: 7] = seg_tab[digit];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge; returns at the negedge where update is seen (or the bound expires).
    task automatic wait_update(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        do begin
            @(negedge clock);
            cycles++;
            if (busy6) busy_cnt++;
        end while (!upd6 && cycles < 100);
    endtask

    task automatic check_display(input string tag, input logic [31:0] v);
        check({tag, "/upd10"}, 70'(upd10), 70'(1'b1));
        check({tag, "/hex6"},  70'(hex6),  exp_hex(v, 6));
        check({tag, "/ovf6"},  70'(ovf6),  70'(exp_ovf(v, 6)));
        check({tag, "/hex10"}, hex10,      exp_hex(v, 10));
        check({tag, "/ovf10"}, 70'(ovf10), 70'(exp_ovf(v, 10)));
    endtask

    task automatic run_value(input string tag, input logic [31:0] v);
        int cyc, bc;
        value_in = v;
        wait_update(cyc, bc);
        check({tag, "/latency"}, 70'(cyc), 70'(34));
        check({tag, "/busy_cycles"}, 70'(bc), 70'(33));
        check_display(tag, v);
        @(negedge clock);
        check({tag, "/upd_pulse"}, 70'(upd6), 70'(1'b0));
        $display("[TB] value %0d -> hex6 %h ovf %0b", v, hex6, ovf6);
    endtask

    initial begin
        int          cyc, bc, extra;
        logic [31:0] cur_v, v;

        reset    = 1'b1;
        value_in = 32'd0;
        repeat (3) @(negedge clock);
        check("rst/hex6",  70'(hex6), 70'({6{7'h7F}}));
        check("rst/hex10", hex10,     {10{7'h7F}});
        check("rst/ovf",   70'(ovf6), 70'(1'b0));
        check("rst/busy",  70'(busy6), 70'(1'b0));
        check("rst/upd",   70'(upd6), 70'(1'b0));

        // Forced first conversion of the value held through reset.
        reset = 1'b0;
        run_value("zero", 32'd0);

        run_value("123456", 32'd123456);
        run_value("1234567", 32'd1234567);
        run_value("max", 32'hFFFF_FFFF);
        cur_v = 32'hFFFF_FFFF;

        for (int i = 0; i < 8; i++) begin
            case (i % 3)
                0:       v = $urandom;
                1:       v = $urandom_range(0, 999999);
                default: v = $urandom_range(0, 99);
            endcase
            if (v == cur_v) v = v + 32'd1;
            run_value($sformatf("rand%0d", i), v);
            cur_v = v;
        end

        // Change mid-conversion: 42 is shown first, then 7 follows.
        value_in = 32'd42;
        repeat (10) @(negedge clock);
        value_in = 32'd7;
        wait_update(cyc, bc);
        check("chg/first_latency", 70'(cyc), 70'(24));
        check_display("chg/first", 32'd42);
        wait_update(cyc, bc);
        check("chg/second_latency", 70'(cyc), 70'(34));
        check_display("chg/second", 32'd7);
        $display("[TB] change 42->7 -> hex6 %h", hex6);
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (upd6) extra++;
        end
        check("chg/extra_updates", 70'(extra), 70'(0));

        // Reset in the middle of converting 999, then the forced re-conversion.
        value_in = 32'd999;
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort/hex6", 70'(hex6), 70'({6{7'h7F}}));
        check("abort/busy", 70'(busy6), 70'(1'b0));
        check("abort/upd",  70'(upd6), 70'(1'b0));
        check("abort/ovf",  70'(ovf6), 70'(1'b0));
        reset = 1'b0;
        wait_update(cyc, bc);
        check("abort/latency", 70'(cyc), 70'(34));
        check_display("abort", 32'd999);
        $display("[TB] reset abort then 999 -> hex6 %h", hex6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
